voice_envelope: RTL and testbench
=================================

# voice_envelope

Eight-voice ADSR envelope generator that consumes the MIDI receiver's per-voice gate and velocity (`on`, `velocity`) and produces one 16-bit amplitude envelope per voice for the downstream oscillator/mixer. A single time-multiplexed update datapath sweeps all voices once per audio sample tick. Peak level scales with velocity. A per-voice active flag is exported for voice allocation.

## Interface
Parameters:
- NUM_VOICES, 8, voices swept per tick
- ENV_WIDTH, 16, envelope level width
- VEL_WIDTH, 3, velocity width from MIDI receiver

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle pulse at audio sample rate; starts a sweep
- gate_in  in  [NUM_VOICES]  note-on per voice (MIDI receiver `on_out`)
- velocity_in  in  [NUM_VOICES][VEL_WIDTH]  per-voice velocity
- attack_step  in  ENV_WIDTH  level increment per tick in ATTACK; 0 = instantaneous
- decay_step  in  ENV_WIDTH  decrement per tick in DECAY; 0 = instantaneous
- sustain_level  in  ENV_WIDTH  absolute sustain target
- release_step  in  ENV_WIDTH  decrement per tick in RELEASE; 0 = instantaneous
- env_out  out  [NUM_VOICES][ENV_WIDTH]  registered envelope per voice
- env_valid  out  1  one-cycle pulse: sweep complete, all env_out updated
- voice_active  out  [NUM_VOICES]  1 while voice state != IDLE
- busy  out  1  sweep in progress
- tick_overrun  out  1  sticky; a sample_tick arrived while busy

## Operation
- Per-voice state: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Stored with level[ENV_WIDTH] and gate_prev.
- Rising edges of gate_in are captured every clk into a sticky pend_on[v]. pend_on is cleared when voice v is processed. A set and a clear in the same cycle resolve to set, so a new edge is never lost.
- peak(v) = {velocity_in[v], {ENV_WIDTH-VEL_WIDTH{1'b1}}}. Velocity 7 gives 0xFFFF; velocity 0 gives 0x1FFF.
- sus(v) = min(sustain_level, peak(v)).
- Voice update when processed. Rules are applied in order:
  - pend_on set: go to ATTACK. Level is kept, so a retrigger from any state is click-free.
  - Otherwise, gate_in low in ATTACK, DECAY or SUSTAIN: go to RELEASE. Level is unchanged this tick.
  - ATTACK: level = min(level + attack_step, peak), computed at ENV_WIDTH+1 bits. When it reaches peak, go to DECAY. If level is already above peak (velocity lowered on retrigger), clamp to peak and go to DECAY.
  - DECAY: level = max(level − decay_step, sus), computed without wrap. When it reaches sus, go to SUSTAIN.
  - SUSTAIN: level tracks sus.
  - RELEASE: level = max(level − release_step, 0). When it reaches 0, go to IDLE.
  - IDLE: level = 0.
  - A step value of 0 sets level to the stage target in that same tick and takes the transition.
- Config inputs and velocity_in are sampled during each voice's own processing cycle. Mid-sweep changes affect only the voices not yet processed.
- voice_active[v] and env_out[v] update together, at the end of voice v's processing cycle.

## Timing
- Sweep sequence:
  - sample_tick sampled high at edge E0 with busy=0: busy rises at E0.
  - Voice i is processed in the cycle after E(i), and its outputs are written at edge E(i+1), for i = 0..7.
  - At E8: busy falls and env_valid is registered high for exactly one cycle.
- Sweep latency: 8 cycles from tick to last update, 9 cycles to env_valid observed high. The minimum tick spacing is 9 cycles.
- A sample_tick seen while busy=1 is dropped, the sweep continues undisturbed, and tick_overrun is set. tick_overrun clears only on reset.
- Reset (asynchronous, any time, including mid-sweep):
  - env_out=0, env_valid=0, voice_active=0, busy=0, tick_overrun=0.
  - All states IDLE, levels 0, pend_on=0, gate_prev=0.
  - Voice index returns to 0.
- First sweep after reset release requires a fresh sample_tick.

## Structure
- Shared package synth_pkg holds:
  - env_state_t enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE)
  - NUM_VOICES, ENV_WIDTH and VEL_WIDTH constants, also used by the MIDI receiver and oscillator bank
- Sub-module env_step: purely combinational single-voice next-state and next-level function (state, level, gate, pend_on, peak, sus, steps). The top level is the sweep counter, the per-voice register arrays, edge capture and output registers.

## Test plan
- Gate voice 0 high, velocity 7, attack_step=0x4000 → env_out[0] after successive ticks is 0x4000, 0x8000, 0xC000, 0xFFFF (DECAY); env_valid pulses 9 cycles after each tick.
- Decay with decay_step=0x1000, sustain_level=0x8000 → level steps down to 0x8000 and holds; releasing gate with release_step=0x2000 → 4 ticks to 0, voice_active[0] drops on the same edge as level reaches 0.
- Velocity 0, sustain_level=0xFFFF → peak 0x1FFF, sustain clamps to 0x1FFF.
- Gate pulse 0→1→0 lasting 2 cycles between ticks → pend_on captured; voice enters ATTACK on the next tick, then RELEASE on the following tick.
- Retrigger in RELEASE at level 0x3000 → ATTACK continues from 0x3000 (no jump to 0).
- Second sample_tick 4 cycles after the first → ignored, tick_overrun=1, single env_valid; then assert rst_n low mid-sweep → all outputs 0 immediately.

Source files
------------

// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the synthesiser voice path (MIDI receiver, envelope
// generator, oscillator bank).
//   NUM_VOICES / ENV_WIDTH / VEL_WIDTH : common widths
//   env_state_t                        : ADSR envelope stage
//   peak_of()                          : velocity-scaled envelope peak
//   sus_of()                           : sustain target clipped to the peak
// -----------------------------------------------------------------------------
package synth_pkg;

    localparam int NUM_VOICES = 8;
    localparam int ENV_WIDTH  = 16;
    localparam int VEL_WIDTH  = 3;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } env_state_t;

    // Velocity fills the top bits, the rest are ones: vel 7 -> 0xFFFF, vel 0 -> 0x1FFF.
    function automatic logic [ENV_WIDTH-1:0] peak_of(input logic [VEL_WIDTH-1:0] vel);
        return {vel, {(ENV_WIDTH - VEL_WIDTH){1'b1}}};
    endfunction

    function automatic logic [ENV_WIDTH-1:0] sus_of(input logic [ENV_WIDTH-1:0] sustain,
                                                    input logic [ENV_WIDTH-1:0] peak);
        return (sustain < peak) ? sustain : peak;
    endfunction

endpackage

// File: rtl/env_step.sv
// -----------------------------------------------------------------------------
// env_step
// Combinational next-state / next-level function for one envelope voice.
//   state_i, level_i       : current stage and level of the voice
//   gate_i, pend_on_i      : live gate and captured note-on edge
//   peak_i, sus_i          : velocity-scaled peak and clipped sustain target
//   *_step_i               : per-tick stage rates (0 = jump to target)
//   state_o, level_o       : stage and level to store for this voice
// -----------------------------------------------------------------------------
module env_step
    import synth_pkg::*;
(
    input  env_state_t             state_i,
    input  logic [ENV_WIDTH-1:0]   level_i,
    input  logic                   gate_i,
    input  logic                   pend_on_i,
    input  logic [ENV_WIDTH-1:0]   peak_i,
    input  logic [ENV_WIDTH-1:0]   sus_i,
    input  logic [ENV_WIDTH-1:0]   attack_step_i,
    input  logic [ENV_WIDTH-1:0]   decay_step_i,
    input  logic [ENV_WIDTH-1:0]   release_step_i,
    output env_state_t             state_o,
    output logic [ENV_WIDTH-1:0]   level_o
);

    // One extra bit so neither the attack sum nor the decay floor can wrap.
    logic [ENV_WIDTH:0] attack_sum;
    logic [ENV_WIDTH:0] decay_floor;

    assign attack_sum  = {1'b0, level_i} + {1'b0, attack_step_i};
    assign decay_floor = {1'b0, sus_i}   + {1'b0, decay_step_i};

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        state_o = state_i;
        level_o = level_i;

        if (pend_on_i) begin
            // Retrigger keeps the current level so the restart is click-free.
            state_o = ATTACK;
        end else if (!gate_i && (state_i inside {ATTACK, DECAY, SUSTAIN})) begin
            state_o = RELEASE;
        end else begin
            unique case (state_i)
                ATTACK: begin
                    // Also covers a level already above a lowered peak.
                    if (attack_step_i == '0 || attack_sum >= {1'b0, peak_i}) begin
                        level_o = peak_i;
                        state_o = DECAY;
                    end else begin
                        level_o = attack_sum[ENV_WIDTH-1:0];
                    end
                end
                DECAY: begin
                    if (decay_step_i == '0 || {1'b0, level_i} <= decay_floor) begin
                        level_o = sus_i;
                        state_o = SUSTAIN;
                    end else begin
                        level_o = level_i - decay_step_i;
                    end
                end
                SUSTAIN: level_o = sus_i;
                RELEASE: begin
                    if (release_step_i == '0 || level_i <= release_step_i) begin
                        level_o = '0;
                        state_o = IDLE;
                    end else begin
                        level_o = level_i - release_step_i;
                    end
                end
                default: begin
                    level_o = '0;
                    state_o = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/voice_envelope.sv
// -----------------------------------------------------------------------------
// voice_envelope
// Eight-voice ADSR envelope generator. One shared env_step datapath is swept
// over all voices, one voice per clock, after each accepted sample_tick.
//   sample_tick      : starts a sweep (dropped and flagged while busy)
//   gate_in          : per-voice note-on level, rising edges latched in pend_on
//   velocity_in      : per-voice velocity, sets the envelope peak
//   attack/decay/release_step, sustain_level : shared envelope settings
//   env_out          : per-voice envelope level
//   env_valid        : one-cycle pulse after the last voice is written
//   voice_active     : per-voice "not IDLE" flag for voice allocation
//   busy             : sweep in progress
//   tick_overrun     : sticky, a tick arrived during a sweep
// -----------------------------------------------------------------------------
module voice_envelope
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int ENV_WIDTH  = synth_pkg::ENV_WIDTH,
    parameter int VEL_WIDTH  = synth_pkg::VEL_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  sample_tick,
    input  logic [NUM_VOICES-1:0]                 gate_in,
    input  logic [NUM_VOICES-1:0][VEL_WIDTH-1:0]  velocity_in,
    input  logic [ENV_WIDTH-1:0]                  attack_step,
    input  logic [ENV_WIDTH-1:0]                  decay_step,
    input  logic [ENV_WIDTH-1:0]                  sustain_level,
    input  logic [ENV_WIDTH-1:0]                  release_step,
    output logic [NUM_VOICES-1:0][ENV_WIDTH-1:0]  env_out,
    output logic                                  env_valid,
    output logic [NUM_VOICES-1:0]                 voice_active,
    output logic                                  busy,
    output logic                                  tick_overrun
);

    localparam int               IDX_W    = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    logic                  busy_q, busy_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  env_valid_q, env_valid_d;
    logic                  overrun_q, overrun_d;
    logic [NUM_VOICES-1:0] gate_prev_q;
    logic [NUM_VOICES-1:0] pend_on_q, pend_on_d;
    logic [NUM_VOICES-1:0] proc_mask;

    env_state_t            state_q [NUM_VOICES];
    logic [ENV_WIDTH-1:0]  level_q [NUM_VOICES];

    logic [ENV_WIDTH-1:0]  cur_peak, cur_sus, step_level;
    env_state_t            step_state;

    // Settings are taken live during the voice's own processing cycle.
    assign cur_peak = peak_of(velocity_in[idx_q]);
    assign cur_sus  = sus_of(sustain_level, cur_peak);

    env_step u_env_step (
        .state_i        (state_q[idx_q]),
        .level_i        (level_q[idx_q]),
        .gate_i         (gate_in[idx_q]),
        .pend_on_i      (pend_on_q[idx_q]),
        .peak_i         (cur_peak),
        .sus_i          (cur_sus),
        .attack_step_i  (attack_step),
        .decay_step_i   (decay_step),
        .release_step_i (release_step),
        .state_o        (step_state),
        .level_o        (step_level)
    );

    always_comb begin
        busy_d      = busy_q;
        idx_d       = idx_q;
        env_valid_d = 1'b0;
        overrun_d   = overrun_q | (sample_tick & busy_q);
        proc_mask   = '0;

        if (busy_q) begin
            proc_mask[idx_q] = 1'b1;
            if (idx_q == LAST_IDX) begin
                busy_d      = 1'b0;
                idx_d       = '0;
                env_valid_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (sample_tick) begin
            busy_d = 1'b1;
            idx_d  = '0;
        end

        // A new edge wins over the clear, so it survives into the next sweep.
        pend_on_d = (pend_on_q & ~proc_mask) | (gate_in & ~gate_prev_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            idx_q       <= '0;
            env_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            gate_prev_q <= '0;
            pend_on_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            env_valid_q <= env_valid_d;
            overrun_q   <= overrun_d;
            gate_prev_q <= gate_in;
            pend_on_q   <= pend_on_d;
        end
    end

    // NOTE: the per-voice arrays are flops, not RAM, so they take the async reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= IDLE;
                level_q[v] <= '0;
            end
        end else if (busy_q) begin
            state_q[idx_q] <= step_state;
            level_q[idx_q] <= step_level;
        end
    end

    // Level and stage registers are written on the same edge, so both outputs move together.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            env_out[v]      = level_q[v];
            voice_active[v] = (state_q[v] != IDLE);
        end
    end

    assign env_valid    = env_valid_q;
    assign busy         = busy_q;
    assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_voice_envelope.sv
// -----------------------------------------------------------------------------
// tb_voice_envelope
// Directed bench for voice_envelope: ADSR stage walk on voice 0, velocity
// clamp, short gate pulse, release retrigger, tick overrun, mid-sweep reset
// and minimum tick spacing.
// -----------------------------------------------------------------------------
module tb_voice_envelope;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sample_tick;
    logic [7:0]       gate_in;
    logic [7:0][2:0]  velocity_in;
    logic [15:0]      attack_step, decay_step, sustain_level, release_step;
    logic [7:0][15:0] env_out;
    logic             env_valid;
    logic [7:0]       voice_active;
    logic             busy;
    logic             tick_overrun;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    voice_envelope dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick   (sample_tick),
        .gate_in       (gate_in),
        .velocity_in   (velocity_in),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .env_out       (env_out),
        .env_valid     (env_valid),
        .voice_active  (voice_active),
        .busy          (busy),
        .tick_overrun  (tick_overrun)
    );

    // Pulses sample_tick for one cycle and waits for env_valid (bounded).
    // Returns on the negedge where env_valid is seen: 9 negedges after the tick.
    task automatic sweep(input string tag);
        int n;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        n = 1;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL %s busy_after_tick: got %b expected 1", tag, busy);
        end
        while (env_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n != 9) begin
            mismatched++;
            $display("FAIL %s valid_latency: got %0d cycles expected 9", tag, n);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        sample_tick   = 1'b0;
        gate_in       = '0;
        velocity_in   = '0;
        attack_step   = 16'h4000;
        decay_step    = 16'h1000;
        sustain_level = 16'h8000;
        release_step  = 16'h2000;
        repeat (3) @(negedge clk);
        compared++;
        if (env_out !== '0 || env_valid !== 1'b0 || voice_active !== 8'h00 ||
            busy !== 1'b0 || tick_overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: got env=%h valid=%b act=%h busy=%b ovr=%b expected all 0",
                     env_out, env_valid, voice_active, busy, tick_overrun);
        end
        rst_n = 1'b1;
        // No tick: nothing may start on its own after reset release.
        repeat (12) @(negedge clk);
        compared++;
        if (busy !== 1'b0 || env_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle: got busy=%b valid=%b expected 0 0", busy, env_valid);
        end
    endtask

    task automatic test_attack();
        logic [15:0] exp_lvl [5] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        velocity_in[0] = 3'd7;
        gate_in[0]     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sweep("attack");
            compared++;
            if (env_out[0] !== exp_lvl[i]) begin
                mismatched++;
                $display("FAIL attack_level[%0d]: got %h expected %h", i, env_out[0], exp_lvl[i]);
            end
            compared++;
            if (voice_active !== 8'h01) begin
                mismatched++;
                $display("FAIL attack_active[%0d]: got %h expected 01", i, voice_active);
            end
        end
    endtask

    task automatic test_decay();
        logic [15:0] exp_lvl [9] = '{16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hBFFF, 16'hAFFF,
                                     16'h9FFF, 16'h8FFF, 16'h8000, 16'h8000};
        for (int i = 0; i < 9; i++) begin
            sweep("decay");
            compared++;
            if (env_out[0] !== exp_lvl[i]) begin
                mismatched++;
                $display("FAIL decay_level[%0d]: got %h expected %h", i, env_out[0], exp_lvl[i]);
            end
        end
    endtask

    task automatic test_release();
        logic [15:0] exp_lvl [4] = '{16'h8000, 16'h6000, 16'h4000, 16'h2000};
        int n;
        @(negedge clk); gate_in[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sweep("release");
            compared++;
            if (env_out[0] !== exp_lvl[i] || voice_active[0] !== 1'b1) begin
                mismatched++;
                $display("FAIL release_level[%0d]: got %h act=%b expected %h act=1",
                         i, env_out[0], voice_active[0], exp_lvl[i]);
            end
        end
        // Last release step: level and active flag must change on the same edge (E1).
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        compared++;
        if (env_out[0] !== 16'h2000 || voice_active[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL release_pre_edge: got %h act=%b expected 2000 act=1",
                     env_out[0], voice_active[0]);
        end
        @(negedge clk);
        compared++;
        if (env_out[0] !== 16'h0000 || voice_active[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL release_zero_edge: got %h act=%b expected 0000 act=0",
                     env_out[0], voice_active[0]);
        end
        n = 2;
        while (env_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n != 9) begin
            mismatched++;
            $display("FAIL release_valid_latency: got %0d cycles expected 9", n);
        end
    endtask

    task automatic test_velocity_clamp();
        logic [15:0] exp_lvl [5] = '{16'h0000, 16'h1FFF, 16'h1FFF, 16'h1FFF, 16'h0000};
        logic        exp_act [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        attack_step    = 16'h0000;
        decay_step     = 16'h0100;
        sustain_level  = 16'hFFFF;
        velocity_in[1] = 3'd0;
        gate_in[1]     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) gate_in[1] = 1'b0;
            sweep("velocity");
            compared++;
            if (env_out[1] !== exp_lvl[i] || voice_active[1] !== exp_act[i]) begin
                mismatched++;
                $display("FAIL velocity_level[%0d]: got %h act=%b expected %h act=%b",
                         i, env_out[1], voice_active[1], exp_lvl[i], exp_act[i]);
            end
        end
    endtask

    task automatic test_gate_pulse();
        logic exp_act [3] = '{1'b1, 1'b1, 1'b0};
        @(negedge clk); gate_in[2] = 1'b1;
        repeat (2) @(negedge clk);
        gate_in[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sweep("gate_pulse");
            compared++;
            if (env_out[2] !== 16'h0000 || voice_active[2] !== exp_act[i]) begin
                mismatched++;
                $display("FAIL gate_pulse[%0d]: got %h act=%b expected 0000 act=%b",
                         i, env_out[2], voice_active[2], exp_act[i]);
            end
        end
    endtask

    task automatic test_retrigger();
        logic [15:0] exp_lvl [5] = '{16'h0000, 16'h3000, 16'h3000, 16'h3000, 16'h6000};
        attack_step    = 16'h3000;
        velocity_in[3] = 3'd7;
        gate_in[3]     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) gate_in[3] = 1'b0;
            if (i == 3) gate_in[3] = 1'b1;
            sweep("retrigger");
            compared++;
            if (env_out[3] !== exp_lvl[i] || voice_active[3] !== 1'b1) begin
                mismatched++;
                $display("FAIL retrigger_level[%0d]: got %h act=%b expected %h act=1",
                         i, env_out[3], voice_active[3], exp_lvl[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int valids = 0;
        int seen_at = -1;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            sample_tick = (c == 4);
            if (env_valid === 1'b1) begin
                valids++;
                seen_at = c;
            end
        end
        compared++;
        if (valids != 1 || seen_at != 9) begin
            mismatched++;
            $display("FAIL overrun_valids: got %0d pulses at %0d expected 1 at 9", valids, seen_at);
        end
        compared++;
        if (tick_overrun !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun_flag: got %b expected 1", tick_overrun);
        end
        // Voice 3 continued its attack: 0x6000 + 0x3000.
        compared++;
        if (env_out[3] !== 16'h9000) begin
            mismatched++;
            $display("FAIL overrun_level: got %h expected 9000", env_out[3]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        gate_in = '0;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL midreset_busy_before: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (env_out !== '0 || env_valid !== 1'b0 || voice_active !== 8'h00 ||
            busy !== 1'b0 || tick_overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_outputs: got env=%h valid=%b act=%h busy=%b ovr=%b expected all 0",
                     env_out, env_valid, voice_active, busy, tick_overrun);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(negedge clk);
        compared++;
        if (busy !== 1'b0 || env_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_no_resume: got busy=%b valid=%b expected 0 0", busy, env_valid);
        end
    endtask

    task automatic test_back_to_back();
        int valids = 0;
        int first_at = -1;
        int last_at = -1;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            sample_tick = (c == 9);
            if (env_valid === 1'b1) begin
                valids++;
                if (first_at < 0) first_at = c;
                last_at = c;
            end
        end
        compared++;
        if (valids != 2 || first_at != 9 || last_at != 18) begin
            mismatched++;
            $display("FAIL back_to_back_valids: got %0d pulses at %0d/%0d expected 2 at 9/18",
                     valids, first_at, last_at);
        end
        compared++;
        if (tick_overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL back_to_back_overrun: got %b expected 0", tick_overrun);
        end
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay();
        test_release();
        test_velocity_clamp();
        test_gate_pulse();
        test_retrigger();
        test_overrun();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
